// File: rtl/ring_write_arbiter_pkg.sv
// Shared definitions for the ring buffer write arbiter.
package ring_write_arbiter_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int DEPTH_DEF  = 3;
   localparam int GAP_DEF    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_GAP   = 2'b10
   } state_e;

   // One-hot grant vector for a requester index.
   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ring_write_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the requester that did not win last time.
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       win_o,
   output logic       valid_o
);

   // Winner selection; win_o is only meaningful while valid_o is high.
   always_comb begin
      valid_o = |req_i;
      win_o   = (req_i == 2'b11) ? ~last_i : req_i[1];
   end

endmodule

// File: rtl/ring_write_arbiter.sv
// Arbitrates two requesters onto the single write port of the circular
// nibble buffer, owns the ring write pointer and enforces a cool-down gap.
//
// state    | meaning
// ST_IDLE  | waiting for a request while the buffer is not full
// ST_GRANT | write strobe and grant driven for exactly one cycle
// ST_GAP   | cool-down, requests and full ignored for GAP cycles
module ring_write_arbiter
   import ring_write_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int GAP    = GAP_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   input  logic              full,
   input  logic              clear,
   output logic              wr_en,
   output logic [1:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [1:0]        gnt,
   output logic              busy
);

   localparam int             TW         = (GAP < 1) ? 1 : $clog2(GAP + 1);
   localparam logic [TW-1:0]  TIMER_LAST = TW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [1:0]     PTR_LAST   = 2'(DEPTH - 1);

   state_e              state_q;
   logic [1:0]          ptr_q;
   logic [1:0]          ptr_d;
   logic                last_q;
   logic                win_q;
   logic [TW-1:0]       timer_q;
   logic                wr_en_q;
   logic [1:0]          gnt_q;
   logic [1:0]          addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                busy_q;

   logic                pick_win;
   logic                pick_valid;

   rr_pick2 u_pick (
      .req_i   (req),
      .last_i  (last_q),
      .win_o   (pick_win),
      .valid_o (pick_valid)
   );

   // Ring pointer advance with wrap at the last slot.
   always_comb begin
      ptr_d = (ptr_q == PTR_LAST) ? 2'd0 : ptr_q + 2'd1;
   end

   // Arbitration FSM with registered outputs; clear outranks all but reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         last_q  <= 1'b1;
         win_q   <= 1'b0;
         timer_q <= '0;
         wr_en_q <= 1'b0;
         gnt_q   <= 2'b00;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
      end else if (clear) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         timer_q <= '0;
         wr_en_q <= 1'b0;
         gnt_q   <= 2'b00;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!full && pick_valid) begin
                  state_q <= ST_GRANT;
                  win_q   <= pick_win;
                  wr_en_q <= 1'b1;
                  gnt_q   <= onehot2(pick_win);
                  addr_q  <= ptr_q;
                  data_q  <= pick_win ? data1 : data0;
                  busy_q  <= 1'b1;
               end
            end
            ST_GRANT: begin
               ptr_q   <= ptr_d;
               last_q  <= win_q;
               timer_q <= '0;
               wr_en_q <= 1'b0;
               gnt_q   <= 2'b00;
               if (GAP == 0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               timer_q <= timer_q + 1'b1;
               if (timer_q == TIMER_LAST) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               wr_en_q <= 1'b0;
               gnt_q   <= 2'b00;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wr_en   = wr_en_q;
   assign gnt     = gnt_q;
   assign wr_addr = addr_q;
   assign wr_data = data_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_ring_write_arbiter.sv
// Bench for ring_write_arbiter: a GAP=8 and a GAP=0 instance share stimulus.
module tb_ring_write_arbiter;

   localparam int DEPTH = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic [3:0] data0 = 4'h0;
   logic [3:0] data1 = 4'h0;
   logic       full = 1'b0;
   logic       clear = 1'b0;

   logic       wr_en8, busy8, wr_en0, busy0;
   logic [1:0] wr_addr8, gnt8, wr_addr0, gnt0;
   logic [3:0] wr_data8, wr_data0;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   ring_write_arbiter #(.DATA_W(4), .DEPTH(DEPTH), .GAP(8)) u8 (
      .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
      .full(full), .clear(clear), .wr_en(wr_en8), .wr_addr(wr_addr8),
      .wr_data(wr_data8), .gnt(gnt8), .busy(busy8)
   );

   ring_write_arbiter #(.DATA_W(4), .DEPTH(DEPTH), .GAP(0)) u0 (
      .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
      .full(full), .clear(clear), .wr_en(wr_en0), .wr_addr(wr_addr0),
      .wr_data(wr_data0), .gnt(gnt0), .busy(busy0)
   );

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: hold = cool-down cycles still to run before arbitration.
   int         gaps [2] = '{8, 0};
   int         m_ptr [2];
   int         m_hold [2];
   bit         m_last [2];
   bit         m_en [2];
   bit         m_busy [2];
   logic [1:0] m_gnt [2];
   logic [1:0] m_addr [2];
   logic [3:0] m_data [2];

   task automatic model_step(input int k);
      bit w;
      if (!rst_n) begin
         m_ptr[k] = 0; m_last[k] = 1'b1; m_hold[k] = 0; m_en[k] = 1'b0;
         m_gnt[k] = 2'b00; m_addr[k] = 2'd0; m_data[k] = 4'h0; m_busy[k] = 1'b0;
      end else if (clear) begin
         m_ptr[k] = 0; m_hold[k] = 0; m_en[k] = 1'b0; m_gnt[k] = 2'b00; m_busy[k] = 1'b0;
      end else if (m_en[k]) begin
         m_ptr[k]  = (m_ptr[k] + 1) % DEPTH;
         m_last[k] = (m_gnt[k] == 2'b10);
         m_en[k]   = 1'b0;
         m_gnt[k]  = 2'b00;
         m_hold[k] = gaps[k];
         m_busy[k] = (gaps[k] > 0);
      end else if (m_hold[k] > 0) begin
         m_hold[k]--;
         m_busy[k] = (m_hold[k] > 0);
      end else if (!full && req != 2'b00) begin
         if (req[0] && req[1]) w = !m_last[k];
         else                  w = req[1];
         m_en[k]   = 1'b1;
         m_gnt[k]  = 2'(1 << w);
         m_addr[k] = 2'(m_ptr[k]);
         m_data[k] = w ? data1 : data0;
         m_busy[k] = 1'b1;
      end
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
      cyc++;
   end

   // Continuous comparison of both instances against the model.
   always @(negedge clk) begin
      if (cyc > 0) begin
         cmp("u8.wr_en", 8'(wr_en8), 8'(m_en[0]));
         cmp("u8.gnt",   8'(gnt8),   8'(m_gnt[0]));
         cmp("u8.busy",  8'(busy8),  8'(m_busy[0]));
         if (m_en[0]) begin
            cmp("u8.wr_addr", 8'(wr_addr8), 8'(m_addr[0]));
            cmp("u8.wr_data", 8'(wr_data8), 8'(m_data[0]));
         end
         cmp("u0.wr_en", 8'(wr_en0), 8'(m_en[1]));
         cmp("u0.gnt",   8'(gnt0),   8'(m_gnt[1]));
         cmp("u0.busy",  8'(busy0),  8'(m_busy[1]));
         if (m_en[1]) begin
            cmp("u0.wr_addr", 8'(wr_addr0), 8'(m_addr[1]));
            cmp("u0.wr_data", 8'(wr_data0), 8'(m_data[1]));
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; clear = 1'b0; full = 1'b0; req = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   int         n, nb, guard;
   logic [1:0] g_log [4];
   logic [1:0] a_log [4];
   logic [3:0] d_log [4];
   int         t_log [4];

   initial begin
      repeat (3) @(negedge clk);
      cmp("rst.wr_en",   8'(wr_en8),   8'h0);
      cmp("rst.gnt",     8'(gnt8),     8'h0);
      cmp("rst.wr_addr", 8'(wr_addr8), 8'h0);
      cmp("rst.wr_data", 8'(wr_data8), 8'h0);
      cmp("rst.busy",    8'(busy8),    8'h0);

      // single request, one cycle latency, busy for 1+GAP cycles
      rst_n = 1'b1; req = 2'b01; data0 = 4'hA;
      @(negedge clk);
      cmp("t1.wr_en",   8'(wr_en8),   8'h1);
      cmp("t1.gnt",     8'(gnt8),     8'h1);
      cmp("t1.wr_addr", 8'(wr_addr8), 8'h0);
      cmp("t1.wr_data", 8'(wr_data8), 8'hA);
      req = 2'b00; nb = 1;
      repeat (12) begin
         @(negedge clk);
         if (busy8) nb++;
      end
      cmp("t1.busy_cycles", 8'(nb), 8'd9);

      // both requesting: alternate, wrap pointer, 10-cycle spacing
      do_reset();
      req = 2'b11; data0 = 4'h3; data1 = 4'h5; n = 0;
      for (int i = 0; i < 4; i++) begin
         g_log[i] = 2'b00; a_log[i] = 2'b00; d_log[i] = 4'h0; t_log[i] = 0;
      end
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (wr_en8 && n < 4) begin
            g_log[n] = gnt8; a_log[n] = wr_addr8; d_log[n] = wr_data8; t_log[n] = c; n++;
         end
      end
      cmp("t2.count", 8'(n), 8'd4);
      for (int i = 0; i < 4; i++) begin
         cmp("t2.gnt",  8'(g_log[i]), (i % 2 == 0) ? 8'h1 : 8'h2);
         cmp("t2.addr", 8'(a_log[i]), 8'(i % 3));
         cmp("t2.data", 8'(d_log[i]), (i % 2 == 0) ? 8'h3 : 8'h5);
         if (i > 0) cmp("t2.spacing", 8'(t_log[i] - t_log[i-1]), 8'd10);
      end

      // GAP=0 instance: back-to-back writes every 2 cycles
      do_reset();
      req = 2'b01; n = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (wr_en0 && n < 4) begin
            a_log[n] = wr_addr0; t_log[n] = c; n++;
         end
      end
      cmp("t3.count", 8'(n), 8'd4);
      for (int i = 0; i < 4; i++) begin
         cmp("t3.addr", 8'(a_log[i]), 8'(i % 3));
         if (i > 0) cmp("t3.spacing", 8'(t_log[i] - t_log[i-1]), 8'd2);
      end

      // full blocks arbitration
      do_reset();
      full = 1'b1; req = 2'b10; n = 0;
      repeat (20) begin
         @(negedge clk);
         if (wr_en8) n++;
      end
      cmp("t4.blocked_writes", 8'(n), 8'd0);
      full = 1'b0;
      @(negedge clk);
      cmp("t4.wr_en", 8'(wr_en8), 8'h1);
      cmp("t4.gnt",   8'(gnt8),   8'h2);

      // clear during gap after two writes
      do_reset();
      req = 2'b01; n = 0; guard = 0;
      while (n < 2 && guard < 40) begin
         @(negedge clk);
         guard++;
         if (wr_en8) n++;
      end
      cmp("t5.writes", 8'(n), 8'd2);
      repeat (3) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      cmp("t5.busy_after_clear",  8'(busy8),  8'h0);
      cmp("t5.wr_en_after_clear", 8'(wr_en8), 8'h0);
      @(negedge clk);
      cmp("t5.wr_en",   8'(wr_en8),   8'h1);
      cmp("t5.wr_addr", 8'(wr_addr8), 8'h0);

      // reset mid-gap restores round-robin priority to requester 0
      req = 2'b11;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cmp("t6.wr_en",   8'(wr_en8),   8'h0);
      cmp("t6.gnt",     8'(gnt8),     8'h0);
      cmp("t6.wr_addr", 8'(wr_addr8), 8'h0);
      cmp("t6.wr_data", 8'(wr_data8), 8'h0);
      cmp("t6.busy",    8'(busy8),    8'h0);
      @(negedge clk);
      cmp("t6.gnt_after", 8'(gnt8), 8'h1);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 199) != 0);
         clear = ($urandom_range(0, 39) == 0);
         full  = ($urandom_range(0, 3) == 0);
         req   = 2'($urandom_range(0, 3));
         data0 = 4'($urandom_range(0, 15));
         data1 = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
